// File: rtl/fifo_burst_pkg.sv
// Shared types and constants for the FIFO burst reader.
package fifo_burst_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;
  localparam int OUT_STAGE_DEPTH = 2;
endpackage

// File: rtl/fifo_burst_reader_out_stage.sv
// burst_out_stage: two-entry registered {last,data} buffer with valid/ready on both sides.
// A beat moves on a side when its valid and ready are both high; data/last hold while valid && !ready.
module burst_out_stage
  import fifo_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready
);
  logic [DATA_WIDTH-1:0] r_head_data, r_tail_data;
  logic                  r_head_last, r_tail_last;
  logic [1:0]            r_occ;
  logic                  w_push, w_pop;

  assign o_ready = (r_occ < 2'(OUT_STAGE_DEPTH));
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_head_data;
  assign o_last  = r_head_last;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head_data <= i_data;
            r_head_last <= i_last;
          end else begin
            r_tail_data <= i_data;
            r_tail_last <= i_last;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'(OUT_STAGE_DEPTH)) begin
            r_head_data <= r_tail_data;
            r_head_last <= r_tail_last;
          end
          r_occ <= r_occ - 2'd1;
        end
        // Push and pop together only happen at occupancy 1: the new word replaces the head.
        2'b11: begin
          r_head_data <= i_data;
          r_head_last <= i_last;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst master for a first-word-fall-through FIFO feeding a valid/ready/last stream.
// Optional partial-burst flush after idle timeout when BURST_TIMEOUT_EN is defined.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 32,
  parameter int TIMEOUT_CYC = 64,
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  input  logic [ADDR_WIDTH:0]   fifo_cnt_i,
  output logic                  fifo_rd_o,
  input  logic [ADDR_WIDTH:0]   burst_len_i,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic                  fwd_valid_o,
  output logic                  fwd_last_o,
  input  logic                  fwd_ready_i,
  output logic                  busy_o
);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = FIFO_DEPTH[ADDR_WIDTH:0];

  state_e              r_state;
  logic [ADDR_WIDTH:0] r_rem;
  logic                w_full_start, w_start, w_stage_ready, w_rd, w_last;
  logic [ADDR_WIDTH:0] w_start_len;

  assign w_full_start = (burst_len_i != '0) && (burst_len_i <= DEPTH_L) &&
                        (fifo_cnt_i >= burst_len_i);

`ifdef BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_idle_cnt;
  logic          w_idle_count, w_timeout;

  assign w_idle_count = (r_state == IDLE) && !fifo_empty_i && !w_full_start;
  assign w_timeout    = w_idle_count && (r_idle_cnt == TW'(TIMEOUT_CYC - 1));
  assign w_start      = w_full_start | w_timeout;
  assign w_start_len  = w_full_start ? burst_len_i : fifo_cnt_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_idle_cnt <= '0;
    else if (!w_idle_count || w_timeout) r_idle_cnt <= '0;
    else                                 r_idle_cnt <= r_idle_cnt + 1'b1;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign w_start          = w_full_start;
  assign w_start_len      = burst_len_i;
`endif

  // Pops stall whenever the output stage is full, which also freezes the beat counter.
  assign w_rd      = (r_state == BURST) && !fifo_empty_i && w_stage_ready;
  assign w_last    = (r_rem == 1);
  assign fifo_rd_o = w_rd;
  assign busy_o    = (r_state != IDLE) || fwd_valid_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= BURST;
            r_rem   <= w_start_len;
          end
        end
        BURST: begin
          if (w_rd) begin
            r_rem <= r_rem - 1'b1;
            if (w_last) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  burst_out_stage #(.DATA_WIDTH(DATA_WIDTH)) u_out_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_rd),
    .i_data  (fifo_data_i),
    .i_last  (w_last),
    .o_ready (w_stage_ready),
    .o_valid (fwd_valid_o),
    .o_data  (fwd_data_o),
    .o_last  (fwd_last_o),
    .i_ready (fwd_ready_i)
  );
endmodule
